// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage
//   Instruction-fetch stage of the 16-bit pipelined CPU. Owns the PC, drives
//   instruction-memory port 1, predicts control-flow targets with a small
//   direct-mapped BTB (2-bit saturating counters) and loads the IF/ID
//   pipeline register consumed by decode.
//
// Ports
//   clk, reset_n        : clock, synchronous active-low reset
//   read_m1, address1   : instruction-memory read enable / fetch address (= PC)
//   data1               : instruction word returned by memory
//   stall, halt         : freeze PC and IF/ID (halt also freezes the BTB)
//   redirect,
//   redirect_pc         : refetch from redirect_pc and flush IF/ID
//   upd_valid, upd_pc,
//   upd_target,
//   upd_taken           : BTB training from a resolved control instruction
//   instr_id, pc_id,
//   pc_plus1_id,
//   pred_taken_id,
//   valid_id            : IF/ID pipeline register
//   fetch_count         : valid instructions delivered to IF/ID (wraps)
// ---------------------------------------------------------------------------
module if_stage #(
    parameter int unsigned          WORD_SIZE    = 16,
    parameter int unsigned          BTB_IDX_BITS = 2,
    parameter logic [WORD_SIZE-1:0] RESET_PC     = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    output logic                 read_m1,
    output logic [WORD_SIZE-1:0] address1,
    input  logic [WORD_SIZE-1:0] data1,
    input  logic                 stall,
    input  logic                 halt,
    input  logic                 redirect,
    input  logic [WORD_SIZE-1:0] redirect_pc,
    input  logic                 upd_valid,
    input  logic [WORD_SIZE-1:0] upd_pc,
    input  logic [WORD_SIZE-1:0] upd_target,
    input  logic                 upd_taken,
    output logic [WORD_SIZE-1:0] instr_id,
    output logic [WORD_SIZE-1:0] pc_id,
    output logic [WORD_SIZE-1:0] pc_plus1_id,
    output logic                 pred_taken_id,
    output logic                 valid_id,
    output logic [WORD_SIZE-1:0] fetch_count
);

    localparam int unsigned BTB_ENTRIES = 1 << BTB_IDX_BITS;
    localparam int unsigned TAG_BITS    = WORD_SIZE - BTB_IDX_BITS;

    // PC and IF/ID register
    logic [WORD_SIZE-1:0] r_pc;
    logic [WORD_SIZE-1:0] r_instr_id;
    logic [WORD_SIZE-1:0] r_pc_id;
    logic [WORD_SIZE-1:0] r_pc_plus1_id;
    logic                 r_pred_taken_id;
    logic                 r_valid_id;
    logic [WORD_SIZE-1:0] r_fetch_count;

    // BTB storage
    logic                 r_btb_valid  [BTB_ENTRIES];
    logic [TAG_BITS-1:0]  r_btb_tag    [BTB_ENTRIES];
    logic [WORD_SIZE-1:0] r_btb_target [BTB_ENTRIES];
    logic [1:0]           r_btb_ctr    [BTB_ENTRIES];

    // Lookup side
    logic [BTB_IDX_BITS-1:0] w_lk_idx;
    logic [TAG_BITS-1:0]     w_lk_tag;
    logic                    w_lk_hit;
    logic                    w_pred_taken;
    logic [WORD_SIZE-1:0]    w_pc_plus1;
    logic [WORD_SIZE-1:0]    w_pc_next;

    // Update side
    logic [BTB_IDX_BITS-1:0] w_upd_idx;
    logic [TAG_BITS-1:0]     w_upd_tag;
    logic                    w_upd_hit;
    logic [1:0]              w_upd_ctr_next;

    assign read_m1  = reset_n & ~halt;
    assign address1 = r_pc;

    assign instr_id      = r_instr_id;
    assign pc_id         = r_pc_id;
    assign pc_plus1_id   = r_pc_plus1_id;
    assign pred_taken_id = r_pred_taken_id;
    assign valid_id      = r_valid_id;
    assign fetch_count   = r_fetch_count;

    // ------------------------------------------------------------------
    // Combinational BTB lookup on the current PC
    // ------------------------------------------------------------------
    assign w_lk_idx     = r_pc[BTB_IDX_BITS-1:0];
    assign w_lk_tag     = r_pc[WORD_SIZE-1:BTB_IDX_BITS];
    assign w_lk_hit     = r_btb_valid[w_lk_idx] && (r_btb_tag[w_lk_idx] == w_lk_tag);
    assign w_pred_taken = w_lk_hit && r_btb_ctr[w_lk_idx][1];
    assign w_pc_plus1   = r_pc + WORD_SIZE'(1);

    // Next-PC priority: halt > redirect > stall > prediction > sequential
    always_comb begin
        w_pc_next = w_pc_plus1;
        if (halt) begin
            w_pc_next = r_pc;
        end else if (redirect) begin
            w_pc_next = redirect_pc;
        end else if (stall) begin
            w_pc_next = r_pc;
        end else if (w_pred_taken) begin
            w_pc_next = r_btb_target[w_lk_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    // ------------------------------------------------------------------
    // IF/ID register: redirect flushes only valid_id, payload is held
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_instr_id      <= '0;
            r_pc_id         <= '0;
            r_pc_plus1_id   <= '0;
            r_pred_taken_id <= 1'b0;
            r_valid_id      <= 1'b0;
            r_fetch_count   <= '0;
        end else if (!halt) begin
            if (redirect) begin
                r_valid_id <= 1'b0;
            end else if (!stall) begin
                r_instr_id      <= data1;
                r_pc_id         <= r_pc;
                r_pc_plus1_id   <= w_pc_plus1;
                r_pred_taken_id <= w_pred_taken;
                r_valid_id      <= 1'b1;
                r_fetch_count   <= r_fetch_count + WORD_SIZE'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // BTB training. Lookup reads the registered arrays, so a same-cycle
    // update at the lookup index becomes visible only on the next cycle.
    // ------------------------------------------------------------------
    assign w_upd_idx = upd_pc[BTB_IDX_BITS-1:0];
    assign w_upd_tag = upd_pc[WORD_SIZE-1:BTB_IDX_BITS];
    assign w_upd_hit = r_btb_valid[w_upd_idx] && (r_btb_tag[w_upd_idx] == w_upd_tag);

    always_comb begin
        w_upd_ctr_next = r_btb_ctr[w_upd_idx];
        if (upd_taken) begin
            if (r_btb_ctr[w_upd_idx] != 2'b11) begin
                w_upd_ctr_next = r_btb_ctr[w_upd_idx] + 2'd1;
            end
        end else begin
            if (r_btb_ctr[w_upd_idx] != 2'b00) begin
                w_upd_ctr_next = r_btb_ctr[w_upd_idx] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
                r_btb_valid[BTB_IDX_BITS'(i)]  <= 1'b0;
                r_btb_tag[BTB_IDX_BITS'(i)]    <= '0;
                r_btb_target[BTB_IDX_BITS'(i)] <= '0;
                r_btb_ctr[BTB_IDX_BITS'(i)]    <= 2'b01;
            end
        end else if (upd_valid && !halt) begin
            if (w_upd_hit) begin
                r_btb_ctr[w_upd_idx] <= w_upd_ctr_next;
                if (upd_taken) begin
                    r_btb_target[w_upd_idx] <= upd_target;
                end
            end else if (upd_taken) begin
                // Allocate on a taken miss, evicting whatever aliased here
                r_btb_valid[w_upd_idx]  <= 1'b1;
                r_btb_tag[w_upd_idx]    <= w_upd_tag;
                r_btb_target[w_upd_idx] <= upd_target;
                r_btb_ctr[w_upd_idx]    <= 2'b10;
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    logic        clk;
    logic        reset_n;
    logic        read_m1;
    logic [15:0] address1;
    logic [15:0] data1;
    logic        stall;
    logic        halt;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        upd_valid;
    logic [15:0] upd_pc;
    logic [15:0] upd_target;
    logic        upd_taken;
    logic [15:0] instr_id;
    logic [15:0] pc_id;
    logic [15:0] pc_plus1_id;
    logic        pred_taken_id;
    logic        valid_id;
    logic [15:0] fetch_count;

    if_stage #(
        .WORD_SIZE   (16),
        .BTB_IDX_BITS(2),
        .RESET_PC    (16'h0000)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .read_m1      (read_m1),
        .address1     (address1),
        .data1        (data1),
        .stall        (stall),
        .halt         (halt),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .upd_valid    (upd_valid),
        .upd_pc       (upd_pc),
        .upd_target   (upd_target),
        .upd_taken    (upd_taken),
        .instr_id     (instr_id),
        .pc_id        (pc_id),
        .pc_plus1_id  (pc_plus1_id),
        .pred_taken_id(pred_taken_id),
        .valid_id     (valid_id),
        .fetch_count  (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: a fixed scramble of the address
    function automatic logic [15:0] mem(input logic [15:0] a);
        logic [31:0] p;
        p = 32'(a) * 32'h9E37 + 32'h1234;
        return p[15:0];
    endfunction

    assign data1 = mem(address1);

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: PC and IF/ID as plain variables, BTB as arrays
    // addressed by pc % 4 with tag pc / 4, counters as integers 0..3.
    // ------------------------------------------------------------------
    localparam int N = 4;
    int          m_pc, m_instr, m_pcid, m_pcp1, m_fc;
    bit          m_pt, m_vid;
    bit          m_bv   [N];
    int          m_btag [N];
    int          m_btgt [N];
    int          m_bctr [N];

    typedef struct {
        logic [15:0] pc, instr, pcid, pcp1, fc;
        logic        vid, pt, rd;
    } exp_t;

    exp_t q[$];

    task automatic model_reset();
        m_pc = 0; m_instr = 0; m_pcid = 0; m_pcp1 = 0; m_fc = 0;
        m_pt = 0; m_vid = 0;
        for (int i = 0; i < N; i++) begin
            m_bv[i] = 0; m_btag[i] = 0; m_btgt[i] = 0; m_bctr[i] = 1;
        end
    endtask

    // Advance the model by one edge using the inputs currently driven,
    // queue the outputs expected right after that edge, then wait for
    // the next falling edge.
    task automatic step();
        exp_t e;
        int idx, ui, npc;
        bit pt;
        if (!reset_n) begin
            model_reset();
        end else begin
            idx = m_pc % N;
            pt  = m_bv[idx] && (m_btag[idx] == m_pc / N) && (m_bctr[idx] >= 2);
            if (halt)          npc = m_pc;
            else if (redirect) npc = int'(redirect_pc);
            else if (stall)    npc = m_pc;
            else if (pt)       npc = m_btgt[idx];
            else               npc = (m_pc + 1) % 65536;
            if (!halt) begin
                if (redirect) m_vid = 0;
                else if (!stall) begin
                    m_instr = int'(mem(16'(m_pc)));
                    m_pcid  = m_pc;
                    m_pcp1  = (m_pc + 1) % 65536;
                    m_pt    = pt;
                    m_vid   = 1;
                    m_fc    = (m_fc + 1) % 65536;
                end
                if (upd_valid) begin
                    ui = int'(upd_pc) % N;
                    if (m_bv[ui] && m_btag[ui] == int'(upd_pc) / N) begin
                        if (upd_taken) begin
                            if (m_bctr[ui] < 3) m_bctr[ui]++;
                            m_btgt[ui] = int'(upd_target);
                        end else if (m_bctr[ui] > 0) m_bctr[ui]--;
                    end else if (upd_taken) begin
                        m_bv[ui] = 1; m_btag[ui] = int'(upd_pc) / N;
                        m_btgt[ui] = int'(upd_target); m_bctr[ui] = 2;
                    end
                end
            end
            m_pc = npc;
        end
        e.pc = 16'(m_pc); e.instr = 16'(m_instr); e.pcid = 16'(m_pcid);
        e.pcp1 = 16'(m_pcp1); e.fc = 16'(m_fc);
        e.vid = m_vid; e.pt = m_pt; e.rd = reset_n && !halt;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic set_in(input bit rn, input bit st, input bit hl, input bit rd,
                          input logic [15:0] rpc, input bit uv, input logic [15:0] up,
                          input logic [15:0] ut, input bit tk);
        reset_n = rn; stall = st; halt = hl; redirect = rd; redirect_pc = rpc;
        upd_valid = uv; upd_pc = up; upd_target = ut; upd_taken = tk;
    endtask

    task automatic idle();
        set_in(1, 0, 0, 0, 16'h0, 0, 16'h0, 16'h0, 0);
    endtask

    // Monitor: compares DUT outputs against the queue after every edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("sb_address1",    address1,      e.pc);
                chk("sb_read_m1",     16'(read_m1),  16'(e.rd));
                chk("sb_valid_id",    16'(valid_id), 16'(e.vid));
                chk("sb_pc_id",       pc_id,         e.pcid);
                chk("sb_instr_id",    instr_id,      e.instr);
                chk("sb_pc_plus1_id", pc_plus1_id,   e.pcp1);
                chk("sb_pred_taken",  16'(pred_taken_id), 16'(e.pt));
                chk("sb_fetch_count", fetch_count,   e.fc);
            end
        end
    end

    initial begin
        int fc_frozen;
        model_reset();
        set_in(0, 0, 0, 0, 16'h0, 0, 16'h0, 16'h0, 0);

        // Reset held two cycles
        repeat (2) begin
            step();
            chk("rst_read_m1",  16'(read_m1),  16'h0);
            chk("rst_address1", address1,      16'h0);
            chk("rst_valid_id", 16'(valid_id), 16'h0);
        end

        // Sequential fetch 0,1,2
        idle();
        repeat (3) step();
        chk("seq_address1",    address1,      16'h3);
        chk("seq_pc_id",       pc_id,         16'h2);
        chk("seq_valid_id",    16'(valid_id), 16'h1);
        chk("seq_fetch_count", fetch_count,   16'h3);

        // Stall two cycles at pc 3
        set_in(1, 1, 0, 0, 16'h0, 0, 16'h0, 16'h0, 0);
        repeat (2) begin
            step();
            chk("stall_address1", address1,    16'h3);
            chk("stall_pc_id",    pc_id,       16'h2);
            chk("stall_fc",       fetch_count, 16'h3);
        end
        idle();
        step();
        chk("unstall_pc_id", pc_id, 16'h3);

        // Redirect wins over stall
        set_in(1, 1, 0, 1, 16'h0020, 0, 16'h0, 16'h0, 0);
        step();
        chk("redir_address1", address1,      16'h0020);
        chk("redir_valid_id", 16'(valid_id), 16'h0);
        idle();
        step();
        chk("redir_pc_id",  pc_id,         16'h0020);
        chk("redir_valid2", 16'(valid_id), 16'h1);

        // Train BTB at 5 -> 0x10, then fetch at 5
        set_in(1, 0, 0, 0, 16'h0, 1, 16'h0005, 16'h0010, 1);
        step();
        set_in(1, 0, 0, 1, 16'h0005, 0, 16'h0, 16'h0, 0);
        step();
        idle();
        step();
        chk("btb_address1", address1,           16'h0010);
        chk("btb_pred",     16'(pred_taken_id), 16'h1);
        chk("btb_pc_id",    pc_id,              16'h0005);

        // Aliasing index with different tag
        set_in(1, 0, 0, 1, 16'h0009, 0, 16'h0, 16'h0, 0);
        step();
        idle();
        step();
        chk("alias_address1", address1,           16'h000A);
        chk("alias_pred",     16'(pred_taken_id), 16'h0);

        // Two not-taken updates drop the counter to 00
        set_in(1, 0, 0, 0, 16'h0, 1, 16'h0005, 16'h0, 0);
        repeat (2) step();
        set_in(1, 0, 0, 1, 16'h0005, 0, 16'h0, 16'h0, 0);
        step();
        idle();
        step();
        chk("nt_address1", address1,           16'h0006);
        chk("nt_pred",     16'(pred_taken_id), 16'h0);

        // Halt at pc 7 with a concurrent update that must be ignored
        set_in(1, 0, 0, 1, 16'h0007, 0, 16'h0, 16'h0, 0);
        step();
        fc_frozen = m_fc;
        set_in(1, 0, 1, 0, 16'h0, 1, 16'h0007, 16'h0030, 1);
        repeat (5) begin
            step();
            chk("halt_read_m1",  16'(read_m1), 16'h0);
            chk("halt_address1", address1,     16'h0007);
            chk("halt_fc",       fetch_count,  16'(fc_frozen));
        end
        idle();
        step();
        chk("halt_release_address1", address1,           16'h0008);
        chk("halt_release_pred",     16'(pred_taken_id), 16'h0);

        // Random traffic including PC wrap, mid-run resets and BTB churn
        for (int n = 0; n < 800; n++) begin
            logic [15:0] rpc, up;
            rpc = ($urandom_range(0, 9) == 0) ? 16'hFFFE : 16'($urandom_range(0, 31));
            up  = ($urandom_range(0, 1) == 0) ? 16'(m_pc) : 16'($urandom_range(0, 31));
            set_in($urandom_range(0, 99) >= 2,
                   $urandom_range(0, 99) < 20,
                   $urandom_range(0, 99) < 10,
                   $urandom_range(0, 99) < 12,
                   rpc,
                   $urandom_range(0, 99) < 40,
                   up,
                   16'($urandom_range(0, 63)),
                   1'($urandom_range(0, 1)));
            step();
        end

        idle();
        step();
        @(posedge clk);
        #2;
        chk("sb_drained", 16'(q.size()), 16'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 16-bit pipelined CPU. Owns the PC and drives instruction-memory port 1 (`read_m1`/`address1`/`data1`). Predicts branch and jump targets with a small direct-mapped BTB using 2-bit saturating counters. Loads the IF/ID pipeline register consumed by the decode stage. Redirects, stalls and halts come from the hazard/branch-resolution logic downstream.

## Interface
Parameters:
- `WORD_SIZE`, 16, datapath and address width
- `BTB_IDX_BITS`, 2, BTB index width (`2**BTB_IDX_BITS` entries)
- `RESET_PC`, 16'h0000, PC value after reset

Ports:
- `clk` in 1: clock. Reset is `reset_n`, synchronous, active-low, on `clk`.
- `reset_n` in 1: synchronous active-low reset
- `read_m1` out 1: instruction-memory read enable
- `address1` out 16: instruction fetch address (= PC)
- `data1` in 16: instruction word from memory
- `stall` in 1: freeze PC and IF/ID (load-use hazard)
- `halt` in 1: CPU halted; freeze everything
- `redirect` in 1: misprediction or jump resolved; refetch from `redirect_pc`
- `redirect_pc` in 16: correct next PC
- `upd_valid` in 1: BTB update strobe for a resolved control instruction
- `upd_pc` in 16: PC of the resolved instruction
- `upd_target` in 16: resolved target
- `upd_taken` in 1: resolved direction
- `instr_id` out 16: IF/ID instruction
- `pc_id` out 16: IF/ID PC
- `pc_plus1_id` out 16: IF/ID PC+1
- `pred_taken_id` out 1: prediction made for `instr_id`
- `valid_id` out 1: IF/ID holds a real instruction
- `fetch_count` out 16: number of valid instructions delivered to IF/ID

## Operation
Reset values:
- `pc` = `RESET_PC`
- `instr_id`, `pc_id`, `pc_plus1_id`, `fetch_count` = 0
- `pred_taken_id` = 0, `valid_id` = 0
- All BTB valid bits = 0, counters = 2'b01
- `read_m1` = 0 while `reset_n` = 0, else `read_m1` = !`halt`

Lookup (combinational, every cycle):
- Index = `pc[BTB_IDX_BITS-1:0]`; tag = `pc[15:BTB_IDX_BITS]`.
- Hit = valid && tag match. Predict taken = hit && `counter[1]`.

Next PC, first match wins:
1. `halt`: hold.
2. `redirect`: `redirect_pc`.
3. `stall`: hold.
4. Predict taken: BTB target.
5. Otherwise: `pc`+1, wrapping 16'hFFFF -> 0.

IF/ID update on each edge:
- `halt`: hold.
- `redirect`: flush; `valid_id` = 0, other fields don't-care and held. Redirect has priority over `stall`.
- `stall`: hold.
- Otherwise load `instr_id` = `data1`, `pc_id` = `pc`, `pc_plus1_id` = `pc`+1, `pred_taken_id` = prediction, `valid_id` = 1. `fetch_count` increments (wraps at 16 bits).

BTB update on edge when `upd_valid` (independent of `stall` and `redirect`; ignored while `halt`):
- Hit at `upd_pc`: counter increments (saturate at 11) if `upd_taken`, else decrements (saturate at 00). Target is overwritten with `upd_target` when `upd_taken`.
- Miss and `upd_taken`: allocate the entry (evict any old one): valid = 1, tag, target, counter = 2'b10.
- Miss and not taken: no change.

Flush scope: this block flushes only IF/ID. Flushing ID/EX on redirect is the hazard unit's job.

## Timing
- `address1` follows `pc` combinationally. Memory returns `data1` on the falling edge, so it is stable at the next rising edge.
- Fetch-to-IF/ID latency: 1 cycle.
- Redirect: `address1` = `redirect_pc` the cycle after assertion, with `valid_id` = 0 that cycle. The target instruction reaches IF/ID one cycle later.
- Same-cycle BTB update and lookup at the same index: the lookup sees the pre-update state. The update is visible from the next cycle.
- Reset mid-operation: all state returns to reset values at the next edge. Pending updates are discarded.
- `stall` and `halt` lasting N cycles hold every register unchanged for exactly N edges.

## Test plan
- Reset held 2 cycles: `read_m1` = 0, `address1` = 0, `valid_id` = 0. After release, `address1` = 0,1,2 on consecutive cycles; `pc_id` = 0,1,2 one cycle later; `valid_id` = 1; `fetch_count` reaches 3.
- `stall` for 2 cycles while `pc` = 3: `address1` stays 3, `pc_id` stays 2, `fetch_count` is frozen. After release, `pc_id` = 3 on the next cycle.
- `redirect` = 1 with `redirect_pc` = 0x0020 while `stall` = 1: next cycle `address1` = 0x20, `valid_id` = 0. The following cycle `pc_id` = 0x20, `valid_id` = 1.
- BTB update (`upd_pc` = 0x0005, `upd_target` = 0x0010, taken), then fetch at 5: `pred_taken_id` = 1 and next `address1` = 0x10. After two not-taken updates at 0x0005 (counter 10 -> 01 -> 00), fetch at 5 gives next `address1` = 6 and `pred_taken_id` = 0.
- Aliasing: with the entry for 0x0005 present, fetch at 0x0009 (same index, different tag) gives no prediction and next `address1` = 0x000A.
- `halt` asserted at `pc` = 7: `read_m1` = 0, and `address1`, IF/ID and `fetch_count` stay frozen for 5 cycles. A concurrent `upd_valid` leaves the BTB unchanged.
